// File: rtl/axis_chk_pkg.sv
// Shared constants for the AXI4-Stream generator/checker pair: error bit
// positions, FSM encodings and the backpressure LFSR tap mask.
package axis_chk_pkg;

  localparam int ERR_DATA = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_STRB = 2;
  localparam int ERR_ID   = 3;
  localparam int ERR_DEST = 4;
  localparam int ERR_W    = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RX   = 1'b1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR with load-on-reset seed and a step enable.
module axis_lfsr16
  import axis_chk_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb    = ^(r_state & LFSR_TAPS);
  assign o_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_state <= i_seed;
    else if (i_en) r_state <= {w_fb, r_state[15:1]};
  end

endmodule

// File: rtl/axis_pkt_chk.sv
// AXI4-Stream packet checker: verifies payload, length, strobes and routing
// of a counting-pattern stream, counts packets/errors and logs the first bad beat.
module axis_pkt_chk
  import axis_chk_pkg::*;
#(
  parameter int          DW        = 32,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              aclk_0,
  input  logic              areset_0,
  input  logic [DW-1:0]     S_AXIS_tdata,
  input  logic [DW/8-1:0]   S_AXIS_tstrb,
  input  logic              S_AXIS_tlast,
  input  logic              S_AXIS_tid,
  input  logic              S_AXIS_tdest,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  input  logic              start,
  input  logic [15:0]       num_pkts,
  input  logic [15:0]       pkt_len,
  input  logic              exp_id,
  input  logic              exp_dest,
  input  logic              throttle_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ERR_W-1:0]  err_flags,
  output logic [DW-1:0]     first_err_word,
  output logic [15:0]       first_err_idx
);

  localparam int SW = DW / 8;

  logic [0:0]       r_state;
  logic [15:0]      r_num_pkts, r_pkt_len, r_pkt_seq, r_widx;
  logic [CNT_W-1:0] r_pkt_cnt, r_err_cnt;
  logic [ERR_W-1:0] r_err_flags;
  logic [DW-1:0]    r_first_word;
  logic [15:0]      r_first_idx;
  logic             r_logged, r_discard, r_pkt_err, r_done;

  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr;
  logic             w_rx, w_beat;
  logic [DW-1:0]    w_exp_data;
  logic [SW-1:0]    w_strb_p1;
  logic             w_strb_bad;
  logic [16:0]      w_widx_p1, w_len17;
  logic             w_at_len, w_short;
  logic [ERR_W-1:0] w_errs;
  logic             w_any, w_eop_err, w_final;
  logic [CNT_W-1:0] w_pkt_cnt_nxt;

  axis_lfsr16 u_lfsr (
    .i_clk   (aclk_0),
    .i_rst   (areset_0),
    .i_en    (w_rx),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:1];

  assign w_rx          = (r_state == ST_RX);
  assign S_AXIS_tready = w_rx & (throttle_en ? w_lfsr[0] : 1'b1);
  assign w_beat        = S_AXIS_tvalid & S_AXIS_tready;

  assign w_exp_data = DW'({r_pkt_seq, r_widx});
  assign w_widx_p1  = {1'b0, r_widx} + 17'd1;
  assign w_len17    = {1'b0, r_pkt_len};
  assign w_at_len   = (w_widx_p1 == w_len17);
  assign w_short    = (w_widx_p1 < w_len17);

  // A last beat's strobes must be a nonzero run of ones starting at bit 0
  assign w_strb_p1  = S_AXIS_tstrb + SW'(1);
  assign w_strb_bad = S_AXIS_tlast ? ((S_AXIS_tstrb == '0) || ((S_AXIS_tstrb & w_strb_p1) != '0))
                                   : (S_AXIS_tstrb != '1);

  always_comb begin
    w_errs           = '0;
    w_errs[ERR_DATA] = (S_AXIS_tdata != w_exp_data);
    w_errs[ERR_LEN]  = S_AXIS_tlast ? w_short : w_at_len;
    w_errs[ERR_STRB] = w_strb_bad;
    w_errs[ERR_ID]   = (S_AXIS_tid != exp_id);
    w_errs[ERR_DEST] = (S_AXIS_tdest != exp_dest);
  end

  assign w_any         = |w_errs;
  assign w_eop_err     = r_discard ? r_pkt_err : (r_pkt_err | w_any);
  assign w_pkt_cnt_nxt = r_pkt_cnt + CNT_W'(1);
  assign w_final       = (r_num_pkts != 16'd0) && (w_pkt_cnt_nxt == CNT_W'(r_num_pkts));

  always_ff @(posedge aclk_0) begin
    if (areset_0) begin
      r_state      <= ST_IDLE;
      r_num_pkts   <= '0;
      r_pkt_len    <= '0;
      r_pkt_seq    <= '0;
      r_widx       <= '0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
      r_err_flags  <= '0;
      r_first_word <= '0;
      r_first_idx  <= '0;
      r_logged     <= 1'b0;
      r_discard    <= 1'b0;
      r_pkt_err    <= 1'b0;
      r_done       <= 1'b0;
    end else if (start) begin
      // Restart wins over any beat presented on the same cycle
      r_state      <= ST_RX;
      r_num_pkts   <= num_pkts;
      r_pkt_len    <= pkt_len;
      r_pkt_seq    <= '0;
      r_widx       <= '0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
      r_err_flags  <= '0;
      r_first_word <= '0;
      r_first_idx  <= '0;
      r_logged     <= 1'b0;
      r_discard    <= 1'b0;
      r_pkt_err    <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_beat) begin
      if (!r_discard) begin
        r_err_flags <= r_err_flags | w_errs;
        if (w_any && !r_logged) begin
          r_logged     <= 1'b1;
          r_first_word <= S_AXIS_tdata;
          r_first_idx  <= r_widx;
        end
      end
      if (S_AXIS_tlast) begin
        r_pkt_cnt <= w_pkt_cnt_nxt;
        r_pkt_seq <= r_pkt_seq + 16'd1;
        r_widx    <= '0;
        r_discard <= 1'b0;
        r_pkt_err <= 1'b0;
        if (w_eop_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (w_final) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
      end else if (!r_discard) begin
        // Over-long packet: length already flagged, swallow beats up to tlast
        r_pkt_err <= r_pkt_err | w_any;
        if (w_at_len) r_discard <= 1'b1;
        else          r_widx    <= r_widx + 16'd1;
      end
    end
  end

  assign busy           = w_rx;
  assign done           = r_done;
  assign pkt_cnt        = r_pkt_cnt;
  assign err_cnt        = r_err_cnt;
  assign err_flags      = r_err_flags;
  assign first_err_word = r_first_word;
  assign first_err_idx  = r_first_idx;

endmodule

// File: tb/tb_axis_pkt_chk.sv
// Directed bench for axis_pkt_chk: clean, corrupted, mis-length, throttled,
// strobe/id and reset-recovery packet streams.
module tb_axis_pkt_chk;

  localparam int DW    = 32;
  localparam int CNT_W = 32;

  logic             aclk_0 = 1'b0;
  logic             areset_0;
  logic [DW-1:0]    S_AXIS_tdata;
  logic [DW/8-1:0]  S_AXIS_tstrb;
  logic             S_AXIS_tlast, S_AXIS_tid, S_AXIS_tdest, S_AXIS_tvalid, S_AXIS_tready;
  logic             start;
  logic [15:0]      num_pkts, pkt_len;
  logic             exp_id, exp_dest, throttle_en;
  logic             busy, done;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;
  logic [4:0]       err_flags;
  logic [DW-1:0]    first_err_word;
  logic [15:0]      first_err_idx;

  int n_chk = 0;
  int n_err = 0;
  int stalls = 0;

  axis_pkt_chk #(.DW(DW), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .aclk_0         (aclk_0),
    .areset_0       (areset_0),
    .S_AXIS_tdata   (S_AXIS_tdata),
    .S_AXIS_tstrb   (S_AXIS_tstrb),
    .S_AXIS_tlast   (S_AXIS_tlast),
    .S_AXIS_tid     (S_AXIS_tid),
    .S_AXIS_tdest   (S_AXIS_tdest),
    .S_AXIS_tvalid  (S_AXIS_tvalid),
    .S_AXIS_tready  (S_AXIS_tready),
    .start          (start),
    .num_pkts       (num_pkts),
    .pkt_len        (pkt_len),
    .exp_id         (exp_id),
    .exp_dest       (exp_dest),
    .throttle_en    (throttle_en),
    .busy           (busy),
    .done           (done),
    .pkt_cnt        (pkt_cnt),
    .err_cnt        (err_cnt),
    .err_flags      (err_flags),
    .first_err_word (first_err_word),
    .first_err_idx  (first_err_idx)
  );

  always #5 aclk_0 = ~aclk_0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat from a negedge and hold it until the checker accepts it
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic id);
    int waits;
    waits = 0;
    @(negedge aclk_0);
    S_AXIS_tdata  = d;
    S_AXIS_tstrb  = s;
    S_AXIS_tlast  = l;
    S_AXIS_tid    = id;
    S_AXIS_tdest  = 1'b0;
    S_AXIS_tvalid = 1'b1;
    while (!S_AXIS_tready) begin
      stalls++;
      waits++;
      if (waits > 64) begin
        check("beat_timeout", 64'(0), 64'(1));
        S_AXIS_tvalid = 1'b0;
        return;
      end
      @(negedge aclk_0);
    end
    @(posedge aclk_0);
  endtask

  task automatic send_pkt(input int seq, input int n, input int bad_idx, input logic [31:0] bad_val,
                          input logic [3:0] last_strb, input logic id);
    for (int w = 0; w < n; w++)
      send_beat((w == bad_idx) ? bad_val : {16'(seq), 16'(w)},
                (w == n - 1) ? last_strb : 4'hF, (w == n - 1), id);
  endtask

  // Pulse start, then scramble the config inputs to show they were latched
  task automatic do_start(input int np, input int pl, input logic eid, input logic thr);
    @(negedge aclk_0);
    S_AXIS_tvalid = 1'b0;
    start         = 1'b1;
    num_pkts      = 16'(np);
    pkt_len       = 16'(pl);
    exp_id        = eid;
    throttle_en   = thr;
    @(negedge aclk_0);
    start    = 1'b0;
    num_pkts = 16'd7;
    pkt_len  = 16'd2;
  endtask

  task automatic settle();
    @(negedge aclk_0);
    S_AXIS_tvalid = 1'b0;
  endtask

  initial begin
    areset_0 = 1'b1;
    S_AXIS_tdata = '0; S_AXIS_tstrb = '0; S_AXIS_tlast = 1'b0;
    S_AXIS_tid = 1'b0; S_AXIS_tdest = 1'b0; S_AXIS_tvalid = 1'b0;
    start = 1'b0; num_pkts = '0; pkt_len = '0;
    exp_id = 1'b0; exp_dest = 1'b0; throttle_en = 1'b0;
    repeat (3) @(posedge aclk_0);
    @(negedge aclk_0);
    areset_0 = 1'b0;

    check("rst_tready", 64'(S_AXIS_tready), 64'(0));
    check("rst_busy",   64'(busy),          64'(0));
    check("rst_done",   64'(done),          64'(0));
    check("rst_pkts",   64'(pkt_cnt),       64'(0));
    check("rst_errs",   64'(err_cnt),       64'(0));
    check("rst_flags",  64'(err_flags),     64'(0));

    // 1: clean stream, throttle off
    do_start(3, 4, 1'b0, 1'b0);
    check("t1_busy", 64'(busy), 64'(1));
    stalls = 0;
    for (int p = 0; p < 3; p++) send_pkt(p, 4, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t1_pkts",   64'(pkt_cnt), 64'(3));
    check("t1_errs",   64'(err_cnt), 64'(0));
    check("t1_done",   64'(done),    64'(1));
    check("t1_idle",   64'(busy),    64'(0));
    check("t1_stalls", 64'(stalls),  64'(0));

    // 2: packet 1 word 2 corrupted
    do_start(3, 4, 1'b0, 1'b0);
    check("t2_cleared", 64'(pkt_cnt), 64'(0));
    send_pkt(0, 4, -1, 32'h0, 4'hF, 1'b0);
    send_pkt(1, 4, 2, 32'hDEADBEEF, 4'hF, 1'b0);
    send_pkt(2, 4, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t2_flags", 64'(err_flags),      64'(5'b00001));
    check("t2_errs",  64'(err_cnt),        64'(1));
    check("t2_pkts",  64'(pkt_cnt),        64'(3));
    check("t2_word",  64'(first_err_word), 64'(32'hDEADBEEF));
    check("t2_idx",   64'(first_err_idx),  64'(2));

    // 3: short packet, over-long packet, then a realigned clean packet
    do_start(3, 4, 1'b0, 1'b0);
    send_pkt(0, 3, -1, 32'h0, 4'hF, 1'b0);
    send_pkt(1, 6, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t3_flags", 64'(err_flags),      64'(5'b00010));
    check("t3_errs",  64'(err_cnt),        64'(2));
    check("t3_pkts",  64'(pkt_cnt),        64'(2));
    check("t3_word",  64'(first_err_word), 64'(32'h0000_0002));
    check("t3_idx",   64'(first_err_idx),  64'(2));
    send_pkt(2, 4, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t3_align_errs", 64'(err_cnt), 64'(2));
    check("t3_align_pkts", 64'(pkt_cnt), 64'(3));
    check("t3_done",       64'(done),    64'(1));

    // 4: throttled, 100 packets of 8 words back to back
    do_start(100, 8, 1'b0, 1'b1);
    stalls = 0;
    for (int p = 0; p < 100; p++) send_pkt(p, 8, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t4_pkts",  64'(pkt_cnt),    64'(100));
    check("t4_errs",  64'(err_cnt),    64'(0));
    check("t4_flags", 64'(err_flags),  64'(0));
    check("t4_done",  64'(done),       64'(1));
    check("t4_stall", 64'(stalls > 0), 64'(1));

    // 5: bad last-beat strobes and wrong tid on every beat
    do_start(1, 4, 1'b0, 1'b0);
    send_pkt(0, 4, -1, 32'h0, 4'b0101, 1'b1);
    settle();
    check("t5_flags", 64'(err_flags),     64'(5'b01100));
    check("t5_errs",  64'(err_cnt),       64'(1));
    check("t5_pkts",  64'(pkt_cnt),       64'(1));
    check("t5_idx",   64'(first_err_idx), 64'(0));

    // 6: unbounded run, reset mid-packet, then a fresh run
    do_start(0, 4, 1'b0, 1'b0);
    send_pkt(0, 4, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t6_unb_pkts", 64'(pkt_cnt), 64'(1));
    check("t6_unb_done", 64'(done),    64'(0));
    check("t6_unb_busy", 64'(busy),    64'(1));
    send_beat({16'd1, 16'd0}, 4'hF, 1'b0, 1'b0);
    send_beat({16'd1, 16'd1}, 4'hF, 1'b0, 1'b0);
    @(negedge aclk_0);
    S_AXIS_tvalid = 1'b0;
    areset_0      = 1'b1;
    @(negedge aclk_0);
    areset_0 = 1'b0;
    check("t6_rst_tready", 64'(S_AXIS_tready),  64'(0));
    check("t6_rst_busy",   64'(busy),           64'(0));
    check("t6_rst_pkts",   64'(pkt_cnt),        64'(0));
    check("t6_rst_word",   64'(first_err_word), 64'(0));
    do_start(1, 4, 1'b0, 1'b0);
    send_pkt(0, 4, -1, 32'h0, 4'hF, 1'b0);
    settle();
    check("t6_pkts",  64'(pkt_cnt),   64'(1));
    check("t6_errs",  64'(err_cnt),   64'(0));
    check("t6_flags", 64'(err_flags), 64'(0));
    check("t6_done",  64'(done),      64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
